// File: rtl/arbitro_de_bus.sv
// Round-robin bus arbiter between the CPU (A) and a secondary requester (B).
// Drives the bus-control op code, operand select and a bounded memory wait.
module arbitro_de_bus #(
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i_Req_A,
    input  logic [1:0] i_Op_A,
    input  logic       i_Req_B,
    input  logic [1:0] i_Op_B,
    input  logic       i_Mem_Listo,
    output logic [1:0] o_Control_Salida,
    output logic       o_Sel_B,
    output logic       o_Ack_A,
    output logic       o_Ack_B,
    output logic       o_Error,
    output logic       o_Ocupado
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] WC_INIT  = 4'(WAIT_CYCLES);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [1:0] r_op;
    logic       r_owner;
    logic       r_ptr;
    logic [3:0] r_wcnt;
    logic [7:0] r_tmo;
    logic [1:0] r_ctrl;
    logic       r_sel_b;
    logic       r_ack_a;
    logic       r_ack_b;
    logic       r_error;
    logic       r_ocupado;

    state_t     w_state_n;
    logic [1:0] w_op_n;
    logic       w_owner_n;
    logic       w_ptr_n;
    logic [3:0] w_wcnt_n;
    logic [7:0] w_tmo_n;
    logic       w_err_n;
    logic       w_win;
    logic       w_busy;
    logic [1:0] w_ctrl_n;
    logic       w_sel_b_n;
    logic       w_ack_a_n;
    logic       w_ack_b_n;
    logic       w_ocupado_n;

    // r_ptr = 0 favours A when both request; it always points at the non-winner
    assign w_win = (i_Req_A && i_Req_B) ? r_ptr : i_Req_B;

    always_comb begin
        w_state_n = r_state;
        w_op_n    = r_op;
        w_owner_n = r_owner;
        w_ptr_n   = r_ptr;
        w_wcnt_n  = r_wcnt;
        w_tmo_n   = r_tmo;
        w_err_n   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_Req_A || i_Req_B) begin
                    w_owner_n = w_win;
                    w_op_n    = w_win ? i_Op_B : i_Op_A;
                    w_ptr_n   = ~w_win;
                    w_state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                w_wcnt_n  = WC_INIT;
                w_tmo_n   = 8'd0;
                w_state_n = (r_op == 2'b00) ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (r_wcnt != 4'd0) begin
                    w_wcnt_n = r_wcnt - 4'd1;
                end else if (i_Mem_Listo) begin
                    w_state_n = S_ACK;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_n = S_ACK;
                    w_err_n   = 1'b1;
                end else begin
                    w_tmo_n = r_tmo + 8'd1;
                end
            end
            S_ACK: begin
                w_wcnt_n  = 4'd0;
                w_tmo_n   = 8'd0;
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they are registered with it
    always_comb begin
        w_busy      = (w_state_n == S_GRANT) || (w_state_n == S_WAIT);
        w_ctrl_n    = w_busy ? w_op_n : 2'b00;
        w_sel_b_n   = w_busy ? w_owner_n : r_sel_b;
        w_ack_a_n   = (w_state_n == S_ACK) && !w_owner_n;
        w_ack_b_n   = (w_state_n == S_ACK) && w_owner_n;
        w_ocupado_n = (w_state_n != S_IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_op      <= 2'b00;
            r_owner   <= 1'b0;
            r_ptr     <= 1'b0;
            r_wcnt    <= 4'd0;
            r_tmo     <= 8'd0;
            r_ctrl    <= 2'b00;
            r_sel_b   <= 1'b0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_error   <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_op      <= w_op_n;
            r_owner   <= w_owner_n;
            r_ptr     <= w_ptr_n;
            r_wcnt    <= w_wcnt_n;
            r_tmo     <= w_tmo_n;
            r_ctrl    <= w_ctrl_n;
            r_sel_b   <= w_sel_b_n;
            r_ack_a   <= w_ack_a_n;
            r_ack_b   <= w_ack_b_n;
            r_error   <= w_err_n;
            r_ocupado <= w_ocupado_n;
        end
    end

    assign o_Control_Salida = r_ctrl;
    assign o_Sel_B          = r_sel_b;
    assign o_Ack_A          = r_ack_a;
    assign o_Ack_B          = r_ack_b;
    assign o_Error          = r_error;
    assign o_Ocupado        = r_ocupado;

endmodule
